// File: rtl/etapa_decodificacion.sv
// Instruction-decode stage: buffers every fetched word in a small FIFO, decodes the
// head, reads a bypassed register file and drives a registered ID/EX bundle.
module etapa_decodificacion #(
  parameter int         FIFO_DEPTH = 4,
  parameter int         NREG       = 16,
  parameter logic [4:0] HALT_OP    = 5'b01011
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Instruccion,
  input  logic        Done,
  input  logic        stall,
  input  logic        flush,
  input  logic        wb_en,
  input  logic [3:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        id_valid,
  output logic [4:0]  id_opcode,
  output logic [3:0]  id_rd,
  output logic [31:0] id_rs1_data,
  output logic [31:0] id_rs2_data,
  output logic [31:0] id_imm,
  output logic        halted,
  output logic        overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] ST_WARM   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;
  localparam logic [1:0] ST_HALTED = 2'd3;

  // A zero HALT_OP would be indistinguishable from an idle fetch bus.
  generate
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        NREG < 2 || NREG > 16 || HALT_OP == 5'd0) begin : g_bad_param
      $error("etapa_decodificacion: unsupported parameter set");
    end
  endgenerate

  logic [1:0]  state;
  logic [PW:0] wr_ptr;
  logic [PW:0] rd_ptr;
  logic [31:0] fifo_mem [FIFO_DEPTH];
  logic [31:0] rf [NREG];

  logic        fifo_empty;
  logic        fifo_full;
  logic        active;
  logic        do_pop;
  logic        do_push;
  logic        push_fits;
  logic [31:0] head;
  logic [3:0]  rs1;
  logic [3:0]  rs2;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign active     = (state == ST_RUN) || (state == ST_DRAIN);
  assign do_pop     = active && !flush && !stall && !fifo_empty;
  assign do_push    = (state == ST_RUN) && !Done && !flush;
  assign push_fits  = !fifo_full || do_pop;

  assign head = fifo_mem[rd_ptr[PW-1:0]];
  assign rs1  = head[22:19];
  assign rs2  = head[18:15];

  // Same-cycle writeback wins over the stored value; register 0 always reads zero.
  always_comb begin
    rs1_val = rf[rs1];
    rs2_val = rf[rs2];
    if (wb_en && wb_addr == rs1) rs1_val = wb_data;
    if (wb_en && wb_addr == rs2) rs2_val = wb_data;
    if (rs1 == 4'd0) rs1_val = '0;
    if (rs2 == 4'd0) rs2_val = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (wb_en && wb_addr != 4'd0) begin
      rf[wb_addr] <= wb_data;
    end
  end

  // At full occupancy a simultaneous pop frees the slot being overwritten.
  always_ff @(posedge clk) begin
    if (!rst && do_push && push_fits) fifo_mem[wr_ptr[PW-1:0]] <= Instruccion;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_WARM;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      id_valid    <= 1'b0;
      id_opcode   <= '0;
      id_rd       <= '0;
      id_rs1_data <= '0;
      id_rs2_data <= '0;
      id_imm      <= '0;
      halted      <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        ST_WARM:  state <= ST_RUN;
        ST_RUN:   if (Done && !flush) state <= ST_DRAIN;
        ST_DRAIN: begin
          if (flush) begin
            state <= ST_RUN;
          end else if (fifo_empty) begin
            state  <= ST_HALTED;
            halted <= 1'b1;
          end
        end
        default: ;
      endcase

      if (active) begin
        if (flush) begin
          wr_ptr   <= '0;
          rd_ptr   <= '0;
          id_valid <= 1'b0;
        end else begin
          if (!stall) id_valid <= do_pop;
          if (state == ST_DRAIN && fifo_empty) id_valid <= 1'b0;
          if (do_pop) begin
            rd_ptr      <= rd_ptr + 1'b1;
            id_opcode   <= head[31:27];
            id_rd       <= head[26:23];
            id_rs1_data <= rs1_val;
            id_rs2_data <= rs2_val;
            id_imm      <= {{13{head[18]}}, head[18:0]};
          end
          if (do_push) begin
            if (push_fits) wr_ptr <= wr_ptr + 1'b1;
            else overflow <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_etapa_decodificacion.sv
// Scoreboard bench for etapa_decodificacion: a queue-based reference model predicts
// each issued bundle; a negedge monitor pops and compares whenever a new one appears.
module tb_etapa_decodificacion;

  localparam int DEPTH = 4;
  localparam int M_WARM = 0, M_RUN = 1, M_DRAIN = 2, M_HALT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] Instruccion = '0;
  logic        Done = 1'b0, stall = 1'b0, flush = 1'b0, wb_en = 1'b0;
  logic [3:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        id_valid, halted, overflow;
  logic [4:0]  id_opcode;
  logic [3:0]  id_rd;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm;

  always #5 clk = ~clk;

  etapa_decodificacion dut (
    .clk(clk), .rst(rst), .Instruccion(Instruccion), .Done(Done), .stall(stall),
    .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .id_valid(id_valid), .id_opcode(id_opcode), .id_rd(id_rd),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .halted(halted), .overflow(overflow)
  );

  typedef struct packed {
    logic [4:0]  op;
    logic [3:0]  rd;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
  } bundle_t;

  bundle_t     exp_q[$];
  logic [31:0] m_q[$];
  logic [31:0] m_rf[16];
  int          m_mode = M_WARM;
  bit          m_valid = 0, m_halted = 0, m_ovf = 0;
  int          errors = 0, checks = 0, issued = 0;
  logic        stall_q = 1'b0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h, required 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] mk(int op, int rd, int rs1, logic [18:0] imm);
    return {op[4:0], rd[3:0], rs1[3:0], imm};
  endfunction

  function automatic logic [31:0] reg_val(logic [3:0] a, bit we, logic [3:0] wa, logic [31:0] wd);
    if (a == 0) return 32'd0;
    if (we && wa == a) return wd;
    return m_rf[a];
  endfunction

  function automatic bundle_t expect_of(logic [31:0] w, bit we, logic [3:0] wa, logic [31:0] wd);
    bundle_t b;
    b.op  = w[31:27];
    b.rd  = w[26:23];
    b.a   = reg_val(w[22:19], we, wa, wd);
    b.b   = reg_val(w[18:15], we, wa, wd);
    b.imm = 32'($signed(w[18:0]));
    return b;
  endfunction

  // Predicts the state after the coming clock edge from this cycle's inputs.
  task automatic model_step(bit r, logic [31:0] ins, bit d, bit st, bit fl,
                            bit we, logic [3:0] wa, logic [31:0] wd);
    int m;
    bit pop;
    logic [31:0] w;
    m = m_mode;
    pop = 0;
    if (r) begin
      m_q.delete();
      m_mode = M_WARM; m_valid = 0; m_halted = 0; m_ovf = 0;
      foreach (m_rf[i]) m_rf[i] = '0;
      return;
    end
    if (m == M_WARM) begin
      m_mode = M_RUN;
    end else if (m == M_RUN || m == M_DRAIN) begin
      if (fl) begin
        m_q.delete();
        m_valid = 0;
        m_mode = M_RUN;
      end else begin
        if (!st) begin
          pop = (m_q.size() > 0);
          m_valid = pop;
        end
        if (pop) begin
          w = m_q.pop_front();
          exp_q.push_back(expect_of(w, we, wa, wd));
        end
        if (m == M_RUN) begin
          if (d) m_mode = M_DRAIN;
          else if (m_q.size() < DEPTH) m_q.push_back(ins);
          else m_ovf = 1;
        end else if (!pop && m_q.size() == 0) begin
          m_mode = M_HALT; m_halted = 1; m_valid = 0;
        end
      end
    end
    if (we && wa != 0) m_rf[wa] = wd;
  endtask

  task automatic step(logic [31:0] ins, bit st = 0, bit fl = 0, bit d = 0, bit we = 0,
                      logic [3:0] wa = 4'd0, logic [31:0] wd = 32'd0, bit r = 0);
    rst = r; Instruccion = ins; Done = d; stall = st; flush = fl;
    wb_en = we; wb_addr = wa; wb_data = wd;
    model_step(r, ins, d, st, fl, we, wa, wd);
    @(posedge clk);
    #1;
    chk("id_valid", {31'd0, id_valid}, {31'd0, m_valid});
    chk("halted", {31'd0, halted}, {31'd0, m_halted});
    chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
  endtask

  always @(posedge clk) stall_q <= stall;

  // A freshly loaded bundle is one that is valid after an edge that was not stalled.
  always @(negedge clk) begin
    bundle_t got, want;
    if (id_valid && !stall_q) begin
      got = {id_opcode, id_rd, id_rs1_data, id_rs2_data, id_imm};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL issue: unexpected bundle %h, none required", got);
      end else begin
        want = exp_q.pop_front();
        issued++;
        if (got !== want) begin
          errors++;
          $display("FAIL issue #%0d: got %h, required %h", issued, got, want);
        end else begin
          $display("issue #%0d op=%02h rd=%0d rs1=%08h rs2=%08h imm=%08h", issued,
                   got.op, got.rd, got.a, got.b, got.imm);
        end
      end
    end
  end

  initial begin
    @(posedge clk);
    #1;
    // Reset for two cycles, then check every output is zero.
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    chk("rst id_valid", {31'd0, id_valid}, 0);
    chk("rst id_opcode", {27'd0, id_opcode}, 0);
    chk("rst id_rd", {28'd0, id_rd}, 0);
    chk("rst id_rs1", id_rs1_data, 0);
    chk("rst id_rs2", id_rs2_data, 0);
    chk("rst id_imm", id_imm, 0);
    chk("rst halted", {31'd0, halted}, 0);
    chk("rst overflow", {31'd0, overflow}, 0);

    // WARM cycle word must vanish; then three words with two-edge latency.
    step(32'hFFFF_FFFF);
    step(32'h0880_0005);
    chk("lat no early issue", {31'd0, id_valid}, 0);
    step(32'h1100_0007);
    chk("lat word1 valid", {31'd0, id_valid}, 1);
    chk("lat word1 rd", {28'd0, id_rd}, 1);
    step(32'h1980_0009);
    chk("lat word2 rd", {28'd0, id_rd}, 2);
    step(mk(0, 5, 1, 19'h00010));
    chk("lat word3 rd", {28'd0, id_rd}, 3);

    // Bypass: rs1=3 popped while register 3 is being written.
    step(mk(2, 4, 3, 19'h0));
    step(mk(1, 7, 3, 19'h0), 0, 0, 0, 1, 4'd3, 32'hDEADBEEF);
    chk("bypass rs1", id_rs1_data, 32'hDEADBEEF);
    step(mk(1, 8, 0, 19'h0), 0, 0, 0, 1, 4'd0, 32'h1234_5678);
    chk("reg0 rs2", id_rs2_data, 0);
    chk("rf rs1 after wb", id_rs1_data, 32'hDEADBEEF);
    step(mk(3, 8, 1, 19'h40000), 0, 0, 0, 1, 4'd0, 32'h1234_5678);
    chk("reg0 after wb0", id_rs2_data, 0);

    // Immediate sign extension.
    step(mk(3, 9, 2, 19'h0007F));
    chk("imm negative", id_imm, 32'hFFFC_0000);
    step(mk(0, 1, 0, 19'h0));
    chk("imm positive", id_imm, 32'h0000_007F);

    // Flush while stalled with three buffered words.
    step(mk(4, 1, 0, 19'h1), 0, 1);
    step(mk(4, 2, 0, 19'h2), 1);
    step(mk(4, 3, 0, 19'h3), 1);
    step(mk(4, 4, 0, 19'h4), 1);
    step(mk(4, 5, 0, 19'h5), 1, 1);
    chk("flush valid", {31'd0, id_valid}, 0);
    step(mk(5, 12, 0, 19'h6));
    chk("flush empty", {31'd0, id_valid}, 0);
    step(mk(5, 13, 0, 19'h7));
    chk("post flush issue", {31'd0, id_valid}, 1);
    chk("post flush rd", {28'd0, id_rd}, 12);

    // Four-cycle stall from empty fills the FIFO without loss.
    step(mk(6, 0, 0, 19'h0), 0, 1);
    for (int i = 0; i < 4; i++) step(mk(6, i + 1, 1, 19'(i)), 1);
    chk("stall4 overflow", {31'd0, overflow}, 0);
    for (int i = 0; i < 6; i++) step(mk(7, i, 2, 19'(i)));

    // Five-cycle stall: only the newest word is dropped.
    step(mk(8, 0, 0, 19'h0), 0, 1);
    for (int i = 0; i < 5; i++) begin
      step(mk(8, i + 1, 1, 19'(i)), 1);
      if (i == 3) chk("stall5 no ovf yet", {31'd0, overflow}, 0);
    end
    chk("stall5 overflow", {31'd0, overflow}, 1);
    for (int i = 0; i < 6; i++) step(mk(9, i, 2, 19'(i)));

    // Randomized traffic.
    for (int i = 0; i < 400; i++)
      step($urandom, $urandom_range(0, 9) < 3, $urandom_range(0, 39) == 0, 0,
           $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)), $urandom);

    // Halt with two buffered words.
    step(mk(10, 0, 0, 19'h0), 0, 1);
    step(mk(10, 1, 0, 19'h1), 1);
    step(mk(10, 2, 0, 19'h2), 1);
    step(mk(11, 0, 0, 19'h0), 0, 0, 1);
    chk("halt word1", {28'd0, id_rd}, 1);
    step($urandom);
    chk("halt word2", {28'd0, id_rd}, 2);
    chk("halt not yet", {31'd0, halted}, 0);
    step($urandom);
    chk("halted set", {31'd0, halted}, 1);
    chk("halted valid", {31'd0, id_valid}, 0);
    for (int i = 0; i < 5; i++) step($urandom, 0, $urandom_range(0, 1) == 1);
    chk("halted quiet", {31'd0, id_valid}, 0);

    // Reset during DRAIN with overflow set.
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(32'hFFFF_FFFF);
    step(mk(12, 1, 0, 19'h1));
    step(mk(12, 2, 0, 19'h2));
    for (int i = 0; i < 5; i++) step(mk(12, 3 + i, 0, 19'h3), 1);
    chk("drain pre ovf", {31'd0, overflow}, 1);
    step(mk(11, 0, 0, 19'h0), 1, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    chk("drain rst valid", {31'd0, id_valid}, 0);
    chk("drain rst opcode", {27'd0, id_opcode}, 0);
    chk("drain rst rd", {28'd0, id_rd}, 0);
    chk("drain rst rs1", id_rs1_data, 0);
    chk("drain rst imm", id_imm, 0);
    chk("drain rst overflow", {31'd0, overflow}, 0);
    chk("drain rst halted", {31'd0, halted}, 0);
    step(32'hFFFF_FFFF);
    step(mk(13, 6, 0, 19'h1));
    step(mk(13, 7, 0, 19'h2));
    chk("restart rd", {28'd0, id_rd}, 6);

    @(negedge clk);
    #1;
    chk("scoreboard drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
